// File: rtl/qec_round_scheduler_if.sv
// Purpose : bundles the measurement, LUT and frame-output handshakes of the QEC round scheduler.
// Ports   : master = scheduler side (drives meas_req/lut_*/out_valid/corr_*), slave = surrounding logic.
// Params  : NQ = correction width, NA = ancilla syndrome width (must match the scheduler's).
interface qec_round_scheduler_if #(
  parameter int NQ = 5,
  parameter int NA = 4
);
  // measurement front-end
  logic          meas_req;
  logic [1:0]    meas_axis;
  logic          meas_valid;
  logic [NA-1:0] meas_ancilla;
  // code lookup table
  logic          lut_issue;
  logic [NA-1:0] lut_ancilla;
  logic [1:0]    lut_axis;
  logic [NQ-1:0] lut_correction;
  // correction frame towards the correction-application logic
  logic          out_valid;
  logic          out_ready;
  logic [NQ-1:0] corr_x;
  logic [NQ-1:0] corr_y;
  logic [NQ-1:0] corr_z;

  modport master (
    output meas_req, meas_axis, input meas_valid, meas_ancilla,
    output lut_issue, lut_ancilla, lut_axis, input lut_correction,
    output out_valid, corr_x, corr_y, corr_z, input out_ready
  );

  modport slave (
    input meas_req, meas_axis, output meas_valid, meas_ancilla,
    input lut_issue, lut_ancilla, lut_axis, output lut_correction,
    input out_valid, corr_x, corr_y, corr_z, output out_ready
  );
endinterface

// File: rtl/qec_round_scheduler.sv
// Purpose : sequences QEC syndrome-extraction rounds (X, Y, Z) around the code LUT and
//           assembles the returned corrections into a per-axis frame.
// Latency : min round = 3 x (MEAS + ISSUE) + DRAIN (LUT_LATENCY + 1) + EMIT; no frame on reset.
// Backpressure: frame and corr_* held while out_valid && !out_ready; no new measurement until accepted.
// Ports   : CLK, RST (sync, active-high), start/stop control, bus (qec_round_scheduler_if.master),
//           busy, done. Optional build macro QEC_SYNDROME_COUNT_EN adds err_count and last_nonzero.
module qec_round_scheduler #(
  parameter int NQ          = 5,
  parameter int NA          = 4,
  parameter int LUT_LATENCY = 2,
  parameter int NUM_ROUNDS  = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic                  stop,
  qec_round_scheduler_if.master bus,
  output logic                  busy,
  output logic                  done
`ifdef QEC_SYNDROME_COUNT_EN
  ,
  output logic [15:0]           err_count,
  output logic                  last_nonzero
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_MEAS, S_ISSUE, S_DRAIN, S_EMIT} state_t;

  state_t        state_q, state_d;
  logic [1:0]    axis_q, axis_d;
  logic [NA-1:0] syn_q;
  logic [15:0]   round_q;
  logic [15:0]   round_inc;
  logic          stop_q;
  logic          done_q;
  logic [NQ-1:0] corr_x_q, corr_y_q, corr_z_q;

  // {valid, axis} tags travelling alongside the LUT pipeline
  logic [LUT_LATENCY-1:0] tag_vld;
  logic [1:0]             tag_axis [LUT_LATENCY];
  logic                   tag_pending;

  logic start_run;   // IDLE -> MEAS this cycle
  logic capture;     // syndrome captured this cycle
  logic accept;      // frame handshake this cycle
  logic finish;      // handshake ends the run
  logic last_round;
  logic hit_limit;

  assign tag_pending = |tag_vld;
  assign round_inc   = round_q + 16'd1;
  assign hit_limit   = (NUM_ROUNDS != 0) && (round_inc == 16'(NUM_ROUNDS));
  // stop raised in the handshake cycle itself still ends the run
  assign last_round  = stop_q | stop | hit_limit;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      axis_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      axis_q  <= axis_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    axis_d    = axis_q;
    start_run = 1'b0;
    capture   = 1'b0;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_MEAS;
          axis_d    = 2'd0;
          start_run = 1'b1;
        end
      end
      S_MEAS: begin
        if (bus.meas_valid) begin
          state_d = S_ISSUE;
          capture = 1'b1;
        end
      end
      S_ISSUE: begin
        if (axis_q == 2'd2) begin
          state_d = S_DRAIN;
        end else begin
          axis_d  = axis_q + 2'd1;
          state_d = S_MEAS;
        end
      end
      S_DRAIN: begin
        if (!tag_pending) state_d = S_EMIT;
      end
      S_EMIT: begin
        if (bus.out_ready) begin
          accept = 1'b1;
          if (last_round) begin
            state_d = S_IDLE;
            finish  = 1'b1;
          end else begin
            state_d = S_MEAS;
            axis_d  = 2'd0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: syndrome capture, tag pipeline, correction frame, round/stop bookkeeping.
  always_ff @(posedge CLK) begin
    if (RST) begin
      syn_q    <= '0;
      round_q  <= 16'd0;
      stop_q   <= 1'b0;
      done_q   <= 1'b0;
      corr_x_q <= '0;
      corr_y_q <= '0;
      corr_z_q <= '0;
      for (int i = 0; i < LUT_LATENCY; i++) begin
        tag_vld[i]  <= 1'b0;
        tag_axis[i] <= 2'd0;
      end
    end else begin
      // the tag pipeline advances in every state so overlapping lookups stay aligned
      tag_vld[0]  <= (state_q == S_ISSUE);
      tag_axis[0] <= axis_q;
      for (int i = 1; i < LUT_LATENCY; i++) begin
        tag_vld[i]  <= tag_vld[i-1];
        tag_axis[i] <= tag_axis[i-1];
      end

      if (capture) syn_q <= bus.meas_ancilla;

      if (start_run)   round_q <= 16'd0;
      else if (accept) round_q <= round_inc;

      if (start_run)             stop_q <= 1'b0;
      else if (busy && stop)     stop_q <= 1'b1;

      done_q <= finish;

      if (start_run || (accept && !finish)) begin
        corr_x_q <= '0;
        corr_y_q <= '0;
        corr_z_q <= '0;
      end else if (tag_vld[LUT_LATENCY-1]) begin
        case (tag_axis[LUT_LATENCY-1])
          2'd0:    corr_x_q <= bus.lut_correction;
          2'd1:    corr_y_q <= bus.lut_correction;
          default: corr_z_q <= bus.lut_correction;
        endcase
      end
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign done           = done_q;
  assign bus.meas_req   = (state_q == S_MEAS);
  assign bus.meas_axis  = (state_q == S_MEAS) ? axis_q : 2'd0;
  assign bus.lut_issue  = (state_q == S_ISSUE);
  assign bus.lut_ancilla = (state_q == S_ISSUE) ? syn_q : '0;
  assign bus.lut_axis   = (state_q == S_ISSUE) ? axis_q : 2'd0;
  assign bus.out_valid  = (state_q == S_EMIT);
  assign bus.corr_x     = corr_x_q;
  assign bus.corr_y     = corr_y_q;
  assign bus.corr_z     = corr_z_q;

`ifdef QEC_SYNDROME_COUNT_EN
  // Nonzero-syndrome statistics for the run and a summary of the last accepted frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      err_count    <= 16'd0;
      last_nonzero <= 1'b0;
    end else begin
      if (start_run)
        err_count <= 16'd0;
      else if ((state_q == S_ISSUE) && (syn_q != '0) && (err_count != 16'hFFFF))
        err_count <= err_count + 16'd1;
      if (accept)
        last_nonzero <= |{corr_x_q, corr_y_q, corr_z_q};
    end
  end
`endif

endmodule

// File: tb/tb_qec_round_scheduler.sv
`timescale 1ns/1ps
module tb_qec_round_scheduler;
  localparam int NQ  = 5;
  localparam int NA  = 4;
  localparam int LAT = 2;
  localparam int NR  = 3;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic start = 1'b0;
  logic stop;
  logic busy, done;
`ifdef QEC_SYNDROME_COUNT_EN
  logic [15:0] err_count;
  logic        last_nonzero;
`endif

  qec_round_scheduler_if #(.NQ(NQ), .NA(NA)) bus ();

  qec_round_scheduler #(.NQ(NQ), .NA(NA), .LUT_LATENCY(LAT), .NUM_ROUNDS(NR)) dut (
    .CLK(CLK), .RST(RST), .start(start), .stop(stop), .bus(bus),
`ifdef QEC_SYNDROME_COUNT_EN
    .err_count(err_count), .last_nonzero(last_nonzero),
`endif
    .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference LUT: any fixed mapping works; axis enters so mis-tagging is visible.
  function automatic logic [NQ-1:0] lut_fn(input logic [1:0] ax, input logic [NA-1:0] a);
    if (a == 4'd0) return '0;
    if (a == 4'b0001 || a == 4'b1011) return 5'b10000;
    return {1'b0, a} ^ {3'b000, ax};
  endfunction

  // Scenario knobs, written only by the stimulus process.
  int            meas_delay = 0;      // 0: meas_valid tied high, else cycles of meas_req per axis
  logic          spurious_idle = 1'b0;
  int            stop_round = -1;     // round index (from 0) whose Y measurement raises stop
  int            stall_tab [4] = '{0, 0, 0, 0};
  logic [NA-1:0] syn_tab [3][3];

  // Model state, written only by the environment/compare process.
  int            issued_cnt = 0;      // axes issued in the current round
  logic [NA-1:0] pend_anc [3];
  logic [NQ-1:0] exp_frame [3];
  int            frames_run = 0;
  int            done_cnt = 0;
  int            req_run = 0;
  int            stall_cnt = 0;
  int            next_kind = 0;       // 1: meas_req due, 2: done due
  int            cyc = 0;
  logic          stop_sent = 1'b0;
  int            model_err = 0;
  logic          model_lnz = 1'b0;
  logic [NQ:0]   lpipe [LAT];

  task automatic set_round(input int r, input logic [NA-1:0] x, input logic [NA-1:0] y, input logic [NA-1:0] z);
    syn_tab[r][0] = x; syn_tab[r][1] = y; syn_tab[r][2] = z;
  endtask

  // Environment (front-end, LUT, sink) plus per-cycle comparison against the round model.
  always @(negedge CLK) begin
    int ax;
    logic [NQ:0] head;
    cyc++;
    if (RST) begin
      issued_cnt = 0; frames_run = 0; stop_sent = 1'b0; req_run = 0; stall_cnt = 0;
      next_kind = 0; model_err = 0; model_lnz = 1'b0;
      for (int i = 0; i < 3; i++) begin pend_anc[i] = '0; exp_frame[i] = '0; end
      for (int i = 0; i < LAT; i++) lpipe[i] = '0;
      bus.meas_valid = 1'b0; bus.meas_ancilla = '0; bus.out_ready = 1'b0;
      bus.lut_correction = '0; stop = 1'b0;
    end else begin
      if (next_kind == 1) check("meas_req_after_handshake", bus.meas_req, 1);
      if (next_kind == 2) check("done_after_last_frame", done, 1);
      next_kind = 0;
`ifdef QEC_SYNDROME_COUNT_EN
      check("err_count", err_count, model_err);
      check("last_nonzero", last_nonzero, model_lnz);
`endif
      if (bus.meas_req || bus.lut_issue || bus.out_valid) check("busy_active", busy, 1);
      if (done) begin done_cnt++; check("busy_at_done", busy, 0); end
      if (bus.lut_issue) begin
        check("lut_axis", bus.lut_axis, issued_cnt);
        check("lut_ancilla", bus.lut_ancilla, pend_anc[issued_cnt % 3]);
        exp_frame[issued_cnt % 3] = lut_fn(2'(issued_cnt), pend_anc[issued_cnt % 3]);
        if (pend_anc[issued_cnt % 3] != 0 && model_err < 65535) model_err++;
        issued_cnt++;
      end else begin
        check("lut_idle_zero", {bus.lut_ancilla, bus.lut_axis}, 0);
      end
      if (bus.meas_req) begin
        check("meas_axis", bus.meas_axis, issued_cnt);
        check("req_vs_valid", bus.out_valid, 0);
        if (issued_cnt == 0) check("corr_clear", {bus.corr_x, bus.corr_y, bus.corr_z}, 0);
      end
      if (bus.out_valid) begin
        check("frame_axes", issued_cnt, 3);
        check("corr_x", bus.corr_x, exp_frame[0]);
        check("corr_y", bus.corr_y, exp_frame[1]);
        check("corr_z", bus.corr_z, exp_frame[2]);
        bus.out_ready = (stall_cnt >= stall_tab[(frames_run < 3) ? frames_run : 3]);
        stall_cnt++;
        if (bus.out_ready) begin
          frames_run++;
          model_lnz = |{exp_frame[0], exp_frame[1], exp_frame[2]};
          next_kind = (stop_sent || frames_run == NR) ? 2 : 1;
          issued_cnt = 0; stall_cnt = 0;
          for (int i = 0; i < 3; i++) exp_frame[i] = '0;
        end
      end else begin
        bus.out_ready = 1'b0;
        stall_cnt = 0;
      end
      if (start && !busy) begin
        issued_cnt = 0; frames_run = 0; stop_sent = 1'b0; model_err = 0;
        for (int i = 0; i < 3; i++) exp_frame[i] = '0;
      end
      // measurement front-end
      ax = (issued_cnt < 3) ? issued_cnt : 0;
      if (meas_delay == 0) begin
        bus.meas_valid = 1'b1;
        bus.meas_ancilla = syn_tab[frames_run % 3][ax];
      end else if (bus.meas_req) begin
        req_run++;
        bus.meas_valid = (req_run == meas_delay);
        bus.meas_ancilla = syn_tab[frames_run % 3][ax];
      end else begin
        if (req_run != 0) check("meas_req_length", req_run, meas_delay);
        req_run = 0;
        bus.meas_valid = spurious_idle && !busy && cyc[0];
        bus.meas_ancilla = 4'b1010;
      end
      if (bus.meas_req && bus.meas_valid) pend_anc[ax] = bus.meas_ancilla;
      stop = (stop_round == frames_run) && bus.meas_req && (issued_cnt == 1) && !stop_sent;
      if (stop) stop_sent = 1'b1;
      // LUT answers LAT cycles after issue; junk otherwise
      head = lpipe[LAT-1];
      bus.lut_correction = head[NQ] ? head[NQ-1:0] : NQ'($urandom);
      for (int i = LAT - 1; i > 0; i--) lpipe[i] = lpipe[i-1];
      lpipe[0] = {bus.lut_issue, lut_fn(bus.lut_axis, bus.lut_ancilla)};
    end
  end

  task automatic check_idle(input string name);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
    check({name, "_meas_req"}, bus.meas_req, 0);
    check({name, "_meas_axis"}, bus.meas_axis, 0);
    check({name, "_lut_issue"}, bus.lut_issue, 0);
    check({name, "_lut_ancilla"}, bus.lut_ancilla, 0);
    check({name, "_lut_axis"}, bus.lut_axis, 0);
    check({name, "_out_valid"}, bus.out_valid, 0);
    check({name, "_corr"}, {bus.corr_x, bus.corr_y, bus.corr_z}, 0);
  endtask

  task automatic pulse_start();
    @(posedge CLK); #1 start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 2000) begin @(posedge CLK); #1; n++; end
    check({name, "_done_seen"}, done, 1);
    @(posedge CLK); #1;
    check({name, "_done_pulse"}, done, 0);
    check({name, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    int n;
    // Run A: NUM_ROUNDS rounds, meas_valid tied high, stalls of 2 and 5 cycles
    set_round(0, 4'b0001, 4'b1011, 4'b0000);
    set_round(1, 4'b0110, 4'b0011, 4'b1101);
    set_round(2, 4'b1000, 4'b0100, 4'b0010);
    stall_tab = '{2, 5, 0, 0};
    repeat (2) @(posedge CLK);
    #1 check_idle("reset_hold");
    @(posedge CLK); #1 RST = 1'b0;
    check_idle("reset");
    pulse_start();
    n = 0;
    while (!bus.out_valid && n < 50) begin @(posedge CLK); #1; n++; end
    check("first_frame_latency", n, 9);
    check("a_corr_x", bus.corr_x, 5'b10000);
    check("a_corr_y", bus.corr_y, 5'b10000);
    check("a_corr_z", bus.corr_z, 5'b00000);
    @(posedge CLK); #1;
    check("a_valid_held", bus.out_valid, 1);
    wait_done("run_a");
    check("run_a_frames", frames_run, 3);
    repeat (10) begin @(posedge CLK); #1 check("a_idle_no_req", bus.meas_req, 0); end

    // Run B: slow front-end, spurious meas_valid in IDLE, stop during round 2 Y
    meas_delay = 7; spurious_idle = 1'b1; stop_round = 1;
    stall_tab = '{0, 0, 0, 0};
    set_round(0, 4'b0001, 4'b0000, 4'b0111);
    set_round(1, 4'b1100, 4'b1111, 4'b0000);
    repeat (6) @(posedge CLK);
    pulse_start();
    wait_done("run_b");
    check("run_b_frames", frames_run, 2);
`ifdef QEC_SYNDROME_COUNT_EN
    check("run_b_err_count", err_count, 4);
    check("run_b_last_nonzero", last_nonzero, 1);
`endif
    repeat (10) begin @(posedge CLK); #1 check("b_idle_no_req", bus.meas_req, 0); end
    spurious_idle = 1'b0; meas_delay = 0; stop_round = -1;

    // Run C: start while busy is ignored, reset during DRAIN, then a clean run
    set_round(0, 4'b0101, 4'b0011, 4'b1001);
    set_round(1, 4'b1110, 4'b0010, 4'b0111);
    set_round(2, 4'b0001, 4'b1011, 4'b1111);
    pulse_start();
    repeat (2) @(posedge CLK);
    #1 start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    n = 0;
    while (!(bus.lut_issue && bus.lut_axis == 2'd2) && n < 100) begin @(posedge CLK); #1; n++; end
    check("c_reached_z_issue", bus.lut_issue, 1);
    @(posedge CLK); #1 RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
    check_idle("rst_in_drain");
    repeat (3) begin @(posedge CLK); #1 check("c_no_frame_after_rst", bus.out_valid, 0); end
    pulse_start();
    wait_done("run_c");
    check("run_c_frames", frames_run, 3);
    @(negedge CLK); #1;
    check("done_pulses_total", done_cnt, 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
